// File: rtl/fc_pkg.sv
// Shared constants, FSM states and the Q16.16 multiply rule for fc_layer.
// The backprop states exist only when FC_BACKPROP_EN is defined.
package fc_pkg;
  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 16;
  localparam int PROD_W    = 2 * DATA_W;
  localparam logic signed [DATA_W-1:0] Q_ONE = 32'h00010000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    MAC       = 3'd2,
    SEND      = 3'd3
`ifdef FC_BACKPROP_EN
    ,
    BP_WAIT   = 3'd4,
    BP_UPDATE = 3'd5
`endif
  } fc_state_t;

  // Full 64-bit signed product, Q16.16 result taken from bits [47:16].
  function automatic logic signed [DATA_W-1:0] qmul(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return DATA_W'((PROD_W'(a) * PROD_W'(b)) >>> FRAC_BITS);
  endfunction
endpackage

// File: rtl/fc_if.sv
// Input, softmax and error handshake bundle of fc_layer.
interface fc_if #(parameter int IDX_W = 3);
  import fc_pkg::*;

  logic                     backprop_ctrl;
  logic signed [DATA_W-1:0] fc_input;
  logic [IDX_W-1:0]         fc_input_idx;
  logic                     fc_in_valid;
  logic                     fc_in_ready;
  logic signed [DATA_W-1:0] sf_input;
  logic [IDX_W-1:0]         sf_input_idx;
  logic                     sf_start;
  logic                     sf_in_ready;
  logic signed [DATA_W-1:0] err_data;
  logic [IDX_W-1:0]         err_idx;
  logic                     err_ready;
  logic                     err_ack;

  modport slave (
    input  backprop_ctrl, fc_input, fc_input_idx, fc_in_valid, sf_in_ready,
           err_data, err_idx, err_ready,
    output fc_in_ready, sf_input, sf_input_idx, sf_start, err_ack
  );

  modport master (
    output backprop_ctrl, fc_input, fc_input_idx, fc_in_valid, sf_in_ready,
           err_data, err_idx, err_ready,
    input  fc_in_ready, sf_input, sf_input_idx, sf_start, err_ack
  );
endinterface

// File: rtl/fc_q_mul.sv
// Combinational Q16.16 signed multiplier shared by the MAC and update passes.
module q_mul
  import fc_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] p
);
  assign p = qmul(a, b);
endmodule

// File: rtl/fc_layer.sv
// Fully connected layer, one Q16.16 MAC per cycle, streaming outputs to softmax.
// Define FC_BACKPROP_EN to build the error-driven weight/bias update pass.
module fc_layer
  import fc_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int N_OUT    = 4,
  parameter int IDX_W    = 3,
  parameter int LR_SHIFT = 4,
  parameter logic signed [DATA_W-1:0] WEIGHT_INIT = 32'h00001000
)(
  input  logic clk,
  input  logic rst,
  fc_if.slave  bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(N_OUT - 1);

  fc_state_t state, state_nx;

  // Arrays span the full index range so any index is in bounds; only valid slots are written.
  logic signed [DATA_W-1:0] x    [DEPTH];
  logic signed [DATA_W-1:0] w    [DEPTH][DEPTH];
  logic signed [DATA_W-1:0] bias [DEPTH];
  logic signed [DATA_W-1:0] acc;
  logic [IDX_W-1:0]         j, cnt;
  logic signed [DATA_W-1:0] mul_a, mul_b, mul_p;
  logic                     in_xfer, in_range, mac_start, out_xfer;

  assign in_xfer   = bus.fc_in_valid && (state == IDLE || state == LOAD);
  assign in_range  = bus.fc_input_idx <= LAST_IN;
  assign mac_start = in_xfer && (bus.fc_input_idx == LAST_IN);
  assign out_xfer  = (state == SEND) && bus.sf_in_ready;

`ifdef FC_BACKPROP_EN
  localparam logic [IDX_W-1:0] BIAS_STEP = IDX_W'(N_IN);
  logic signed [DATA_W-1:0] e;
  logic [IDX_W-1:0]         k;
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{bus.backprop_ctrl, bus.err_data, bus.err_idx, bus.err_ready};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (mac_start) state_nx = MAC;
        else if (in_xfer && in_range) state_nx = LOAD;
`ifdef FC_BACKPROP_EN
        else if (!in_xfer && bus.backprop_ctrl) state_nx = BP_WAIT;
`endif
      end
      LOAD: if (mac_start) state_nx = MAC;
      MAC:  if (cnt == LAST_IN) state_nx = SEND;
      SEND: if (out_xfer) state_nx = (j == LAST_OUT) ? IDLE : MAC;
`ifdef FC_BACKPROP_EN
      // Out-of-range error indices are acknowledged but stay here without an update.
      BP_WAIT:   if (bus.err_ready && bus.err_idx <= LAST_OUT) state_nx = BP_UPDATE;
      BP_UPDATE: if (cnt == BIAS_STEP) state_nx = (k == LAST_OUT) ? IDLE : BP_WAIT;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.fc_in_ready  = 1'b0;
    bus.sf_start     = 1'b0;
    bus.sf_input     = '0;
    bus.sf_input_idx = '0;
    bus.err_ack      = 1'b0;
    case (state)
      IDLE, LOAD: bus.fc_in_ready = 1'b1;
      SEND: begin
        bus.sf_start     = 1'b1;
        bus.sf_input     = acc;
        bus.sf_input_idx = j;
      end
`ifdef FC_BACKPROP_EN
      BP_WAIT: bus.err_ack = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    mul_a = x[cnt];
    mul_b = w[j][cnt];
`ifdef FC_BACKPROP_EN
    if (state == BP_UPDATE) begin
      mul_a = e;
      mul_b = x[cnt];
    end
`endif
  end

  q_mul u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        x[r]    <= '0;
        bias[r] <= '0;
        for (int c = 0; c < DEPTH; c++) w[r][c] <= WEIGHT_INIT;
      end
      acc <= '0;
      j   <= '0;
      cnt <= '0;
`ifdef FC_BACKPROP_EN
      e   <= '0;
      k   <= '0;
`endif
    end else begin
      if (in_xfer && in_range) x[bus.fc_input_idx] <= bus.fc_input;
      case (state)
        IDLE, LOAD: if (mac_start) begin
          j   <= '0;
          cnt <= '0;
          acc <= bias[0];
        end
        MAC: begin
          acc <= acc + mul_p;
          cnt <= cnt + IDX_W'(1);
        end
        SEND: if (out_xfer && j != LAST_OUT) begin
          j   <= j + IDX_W'(1);
          cnt <= '0;
          acc <= bias[j + IDX_W'(1)];
        end
`ifdef FC_BACKPROP_EN
        BP_WAIT: if (bus.err_ready) begin
          e   <= bus.err_data;
          k   <= bus.err_idx;
          cnt <= '0;
        end
        BP_UPDATE: begin
          if (cnt == BIAS_STEP) bias[k] <= bias[k] - (e >>> LR_SHIFT);
          else                  w[k][cnt] <= w[k][cnt] - (mul_p >>> LR_SHIFT);
          cnt <= cnt + IDX_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer.sv
// Scoreboard bench for fc_layer with N_IN=2, N_OUT=4, LR_SHIFT=4.
// With FC_BACKPROP_EN defined it also runs an error-driven update pass.
module tb_fc_layer;
  import fc_pkg::*;

  localparam int N_IN     = 2;
  localparam int N_OUT    = 4;
  localparam int IDX_W    = 3;
  localparam int LR_SHIFT = 4;
  localparam logic signed [31:0] W_INIT = 32'h00001000;
  localparam logic signed [31:0] X_HALF = 32'h00008000;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      val;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fc_if #(.IDX_W(IDX_W)) bus ();

  fc_layer #(
    .N_IN        (N_IN),
    .N_OUT       (N_OUT),
    .IDX_W       (IDX_W),
    .LR_SHIFT    (LR_SHIFT),
    .WEIGHT_INIT (W_INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  sb_item_t sb_q[$];
  int compare_count  = 0;
  int mismatch_count = 0;
  int xfer_count     = 0;

  logic signed [31:0] m_x    [N_IN];
  logic signed [31:0] m_w    [N_OUT][N_IN];
  logic signed [31:0] m_bias [N_OUT];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic signed [31:0] ref_mul(input logic signed [31:0] a, input logic signed [31:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return p[47:16];
  endfunction

  function automatic void modelReset();
    for (int r = 0; r < N_OUT; r++) begin
      m_bias[r] = '0;
      for (int c = 0; c < N_IN; c++) m_w[r][c] = W_INIT;
    end
    for (int c = 0; c < N_IN; c++) m_x[c] = '0;
  endfunction

  function automatic void pushExpected(input int n);
    logic signed [31:0] acc;
    sb_item_t it;
    for (int jj = 0; jj < n; jj++) begin
      acc = m_bias[jj];
      for (int i = 0; i < N_IN; i++) acc = acc + ref_mul(m_x[i], m_w[jj][i]);
      it.idx = IDX_W'(jj);
      it.val = acc;
      sb_q.push_back(it);
    end
  endfunction

  // Each accepted softmax transfer is checked against the oldest expectation.
  always @(negedge clk) begin
    sb_item_t it;
    if (!rst && bus.sf_start && bus.sf_in_ready) begin
      xfer_count++;
      if (sb_q.size() == 0) checkOutput("sb_underflow", sb_q.size(), 1);
      else begin
        it = sb_q.pop_front();
        checkOutput("out_idx", 32'(bus.sf_input_idx), 32'(it.idx));
        checkOutput("out_val", bus.sf_input, it.val);
      end
    end
  end

  task automatic sendElem(input logic [IDX_W-1:0] idx, input logic signed [31:0] val);
    int n = 0;
    while (!bus.fc_in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.fc_in_ready) checkOutput("in_ready_timeout", 32'(bus.fc_in_ready), 1);
    bus.fc_input_idx = idx;
    bus.fc_input     = val;
    bus.fc_in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.fc_in_valid  = 1'b0;
  endtask

  task automatic applyStimulus(input logic signed [31:0] x0, input logic signed [31:0] x1, input int n_expect);
    m_x[0] = x0;
    m_x[1] = x1;
    pushExpected(n_expect);
    sendElem(0, x0);
    sendElem(1, x1);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", sb_q.size(), 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef FC_BACKPROP_EN
  task automatic sendError(input logic [IDX_W-1:0] idx, input logic signed [31:0] val);
    int n = 0;
    while (!bus.err_ack && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("err_ack_wait", 32'(bus.err_ack), 1);
    bus.err_idx   = idx;
    bus.err_data  = val;
    bus.err_ready = 1'b1;
    @(posedge clk); #1;
    bus.err_ready = 1'b0;
    if (idx < N_OUT) begin
      for (int i = 0; i < N_IN; i++) m_w[idx][i] = m_w[idx][i] - (ref_mul(val, m_x[i]) >>> LR_SHIFT);
      m_bias[idx] = m_bias[idx] - (val >>> LR_SHIFT);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    int n;
    logic [31:0] held_val;
    logic [IDX_W-1:0] held_idx;

    bus.backprop_ctrl = 1'b0;
    bus.fc_input      = '0;
    bus.fc_input_idx  = '0;
    bus.fc_in_valid   = 1'b0;
    bus.sf_in_ready   = 1'b1;
    bus.err_data      = '0;
    bus.err_idx       = '0;
    bus.err_ready     = 1'b0;
    modelReset();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.fc_in_ready), 1);
    checkOutput("rst_sf_start", 32'(bus.sf_start), 0);
    checkOutput("rst_err_ack", 32'(bus.err_ack), 0);
    checkOutput("rst_sf_input", bus.sf_input, 0);
    checkOutput("rst_sf_idx", 32'(bus.sf_input_idx), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic forward pass");
    start = xfer_count;
    applyStimulus(Q_ONE, X_HALF, N_OUT);
    waitDrain(200);
    checkOutput("pass1_xfers", xfer_count - start, N_OUT);

    $display("[TB] softmax back-pressure");
    bus.sf_in_ready = 1'b0;
    start = xfer_count;
    applyStimulus(Q_ONE, X_HALF, N_OUT);
    n = 0;
    while (!bus.sf_start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("stall_reach_send", 32'(bus.sf_start), 1);
    held_val = bus.sf_input;
    held_idx = bus.sf_input_idx;
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("stall_start", 32'(bus.sf_start), 1);
      checkOutput("stall_val", bus.sf_input, held_val);
      checkOutput("stall_idx", 32'(bus.sf_input_idx), 32'(held_idx));
    end
    bus.sf_in_ready = 1'b1;
    waitDrain(200);
    checkOutput("stall_xfers", xfer_count - start, N_OUT);

    $display("[TB] out-of-range input index");
    start = xfer_count;
    sendElem(5, 32'h7FFF0000);
    checkOutput("bad_idx_ready", 32'(bus.fc_in_ready), 1);
    applyStimulus(Q_ONE, X_HALF, N_OUT);
    waitDrain(200);
    checkOutput("bad_idx_xfers", xfer_count - start, N_OUT);

`ifdef FC_BACKPROP_EN
    $display("[TB] backprop update pass");
    bus.backprop_ctrl = 1'b1;
    @(posedge clk); #1;
    bus.backprop_ctrl = 1'b0;
    checkOutput("bp_err_ack", 32'(bus.err_ack), 1);
    sendError(5, Q_ONE);
    sendError(0, Q_ONE);
    sendError(1, '0);
    sendError(2, '0);
    sendError(3, '0);
    n = 0;
    while (!bus.fc_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp_back_idle", 32'(bus.fc_in_ready), 1);
    start = xfer_count;
    applyStimulus(Q_ONE, X_HALF, N_OUT);
    waitDrain(200);
    checkOutput("bp_pass_xfers", xfer_count - start, N_OUT);
`else
    $display("[TB] backprop request without the update pass built");
    bus.backprop_ctrl = 1'b1;
    bus.err_ready     = 1'b1;
    bus.err_data      = Q_ONE;
    bus.err_idx       = '0;
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("nobp_err_ack", 32'(bus.err_ack), 0);
      checkOutput("nobp_in_ready", 32'(bus.fc_in_ready), 1);
    end
    bus.backprop_ctrl = 1'b0;
    bus.err_ready     = 1'b0;
    start = xfer_count;
    applyStimulus(Q_ONE, X_HALF, N_OUT);
    waitDrain(200);
    checkOutput("nobp_xfers", xfer_count - start, N_OUT);
`endif

    $display("[TB] reset during MAC of output 2");
    start = xfer_count;
    applyStimulus(Q_ONE, X_HALF, 2);
    n = 0;
    while ((xfer_count - start) < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rst_pre_xfers", xfer_count - start, 2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_sf_start", 32'(bus.sf_start), 0);
    checkOutput("midrst_in_ready", 32'(bus.fc_in_ready), 1);
    checkOutput("midrst_sf_input", bus.sf_input, 0);
    checkOutput("midrst_sf_idx", 32'(bus.sf_input_idx), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    sb_q.delete();
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midrst_no_out", xfer_count - start, 2);

    start = xfer_count;
    applyStimulus(Q_ONE, X_HALF, N_OUT);
    waitDrain(200);
    checkOutput("post_rst_xfers", xfer_count - start, N_OUT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end
endmodule
